bus_gate_arbiter: RTL and testbench

//  Round-robin arbiter/controller for the shared internal CPU bus. Four

---
 rtl/bus_gate_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_bus_gate_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bus_gate_arbiter.sv
// -----------------------------------------------------------------------------
// bus_gate_arbiter
//
// Round-robin owner/controller for the shared internal CPU bus. Four sources
// (e.g. PC, MDR, ALU, MARMUX) request the bus. Exactly one of them is granted at
// a time. The block drives the one-hot gate select and the muxed bus value.
// Ownership is bounded by a hold limit, and an optional one-cycle turnaround
// can be inserted between owners.
//
// Parameters
//   N         bus/data width in bits
//   MAX_HOLD  max consecutive granted cycles per ownership (>= 1)
//   TURN      dead (no-grant) cycles between owners: 0 or 1
//
// Ports
//   Clk        in   1        system clock, rising edge
//   Reset_n    in   1        asynchronous reset, active low
//   Req        in   4        request per source; bit i = source i
//   Data_In    in   4*N      packed source data; source i at [i*N +: N]
//   Grant      out  4        registered one-hot gate select; 0000 = bus idle
//   Bus_Out    out  N        Data_In of granted source; all ones when idle
//   Bus_Valid  out  1        |Grant
//   Timeout    out  1        1-cycle pulse after an ownership is force-ended
//   Hold_Cnt   out  HW       cycles the current owner has held the bus
//   dbg_state  out  2        FSM state: 0 = IDLE, 1 = OWN, 2 = GAP
//
// Handshake: a source owns the bus for every cycle in which its Grant bit is
// high. Req is sampled on the rising edge, and Grant follows one cycle later.
// There is no combinational path from Req to Grant. A source that is granted
// keeps the bus while its Req stays high, up to MAX_HOLD cycles. Dropping Req
// releases the bus at the next edge.
// -----------------------------------------------------------------------------
module bus_gate_arbiter #(
    parameter int N        = 16,
    parameter int MAX_HOLD = 8,
    parameter int TURN     = 1
) (
    input  logic                              Clk,
    input  logic                              Reset_n,
    input  logic [3:0]                        Req,
    input  logic [4*N-1:0]                    Data_In,
    output logic [3:0]                        Grant,
    output logic [N-1:0]                      Bus_Out,
    output logic                              Bus_Valid,
    output logic                              Timeout,
    output logic [$clog2(MAX_HOLD+1)-1:0]     Hold_Cnt,
    output logic [1:0]                        dbg_state
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t        state;
    logic [1:0]    owner;
    logic [1:0]    ptr;

    // -------------------------------------------------------------------------
    // Round-robin pick: the first requester found while scanning
    // ptr, ptr+1, ... (mod 4). Returns {found, index}. The loop runs from the
    // farthest slot back to the nearest, so the nearest requester is written last.
    // -------------------------------------------------------------------------
    function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] start);
        logic [1:0] idx;
        logic [2:0] res;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic          owner_req;
    logic          at_limit;
    logic          release_now;
    logic          forced;
    logic [1:0]    arb_ptr;
    logic [2:0]    win;

    state_t        nxt_state;
    logic [3:0]    nxt_grant;
    logic [1:0]    nxt_owner;
    logic [1:0]    nxt_ptr;
    logic [HW-1:0] nxt_hold;
    logic          nxt_timeout;

    assign owner_req   = Req[owner];
    assign at_limit    = (Hold_Cnt == HOLD_MAX);
    assign release_now = (state == S_OWN) && (!owner_req || at_limit);
    // A voluntary drop on the limit cycle is not counted as a timeout.
    assign forced      = (state == S_OWN) && owner_req && at_limit;
    // A release moves the pointer past the old owner. With TURN=0, the same-edge
    // re-arbitration must already use that advanced pointer.
    assign arb_ptr     = release_now ? (owner + 2'd1) : ptr;
    assign win         = rr_pick(Req, arb_ptr);

    always_comb begin
        nxt_state   = state;
        nxt_grant   = Grant;
        nxt_owner   = owner;
        nxt_ptr     = ptr;
        nxt_hold    = Hold_Cnt;
        nxt_timeout = 1'b0;

        case (state)
            S_IDLE, S_GAP: begin
                if (win[2]) begin
                    nxt_state = S_OWN;
                    nxt_grant = 4'b0001 << win[1:0];
                    nxt_owner = win[1:0];
                    nxt_hold  = HOLD_ONE;
                end else begin
                    nxt_state = S_IDLE;
                    nxt_grant = 4'b0000;
                    nxt_hold  = '0;
                end
            end

            S_OWN: begin
                if (!release_now) begin
                    // Below the limit here, so the increment cannot pass
                    // MAX_HOLD.
                    nxt_hold = Hold_Cnt + HOLD_ONE;
                end else begin
                    nxt_ptr     = owner + 2'd1;
                    nxt_timeout = forced;
                    if (TURN != 0) begin
                        nxt_state = S_GAP;
                        nxt_grant = 4'b0000;
                        nxt_hold  = '0;
                    end else if (win[2]) begin
                        // The old owner can win again if it is the only
                        // requester.
                        nxt_state = S_OWN;
                        nxt_grant = 4'b0001 << win[1:0];
                        nxt_owner = win[1:0];
                        nxt_hold  = HOLD_ONE;
                    end else begin
                        nxt_state = S_IDLE;
                        nxt_grant = 4'b0000;
                        nxt_hold  = '0;
                    end
                end
            end

            default: begin
                nxt_state = S_IDLE;
                nxt_grant = 4'b0000;
                nxt_hold  = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= S_IDLE;
            Grant    <= 4'b0000;
            owner    <= 2'd0;
            ptr      <= 2'd0;
            Hold_Cnt <= '0;
            Timeout  <= 1'b0;
        end else begin
            state    <= nxt_state;
            Grant    <= nxt_grant;
            owner    <= nxt_owner;
            ptr      <= nxt_ptr;
            Hold_Cnt <= nxt_hold;
            Timeout  <= nxt_timeout;
        end
    end

    // -------------------------------------------------------------------------
    // Bus mux. It is driven from the registered Grant only. An idle bus reads all
    // ones.
    // -------------------------------------------------------------------------
    always_comb begin
        Bus_Out = {N{1'b1}};
        for (int i = 0; i < 4; i++) begin
            if (Grant[i]) begin
                Bus_Out = Data_In[i*N +: N];
            end
        end
    end

    assign Bus_Valid = |Grant;
    assign dbg_state = state;

endmodule

// File: tb/tb_bus_gate_arbiter.sv
module tb_bus_gate_arbiter;

    // ---------------------------------------------------------------- clock/reset
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset_n;
    logic [3:0]  req0, req1;
    logic [63:0] data_in;

    logic [3:0]  g0, g1;
    logic [15:0] bus0, bus1;
    logic        v0, v1, t0, t1;
    logic [3:0]  h0;
    logic [2:0]  h1;
    logic [1:0]  s0, s1;

    // u0: MAX_HOLD=8, TURN=1.  u1: MAX_HOLD=4, TURN=0.
    bus_gate_arbiter #(.N(16), .MAX_HOLD(8), .TURN(1)) u0 (
        .Clk(Clk), .Reset_n(Reset_n), .Req(req0), .Data_In(data_in),
        .Grant(g0), .Bus_Out(bus0), .Bus_Valid(v0), .Timeout(t0),
        .Hold_Cnt(h0), .dbg_state(s0)
    );

    bus_gate_arbiter #(.N(16), .MAX_HOLD(4), .TURN(0)) u1 (
        .Clk(Clk), .Reset_n(Reset_n), .Req(req1), .Data_In(data_in),
        .Grant(g1), .Bus_Out(bus1), .Bus_Valid(v1), .Timeout(t1),
        .Hold_Cnt(h1), .dbg_state(s1)
    );

    // ---------------------------------------------------------------- scoreboard
    // word = {grant[3:0], timeout, hold[3:0], valid, bus[15:0]}
    logic [25:0] exp_q[$];
    int passed = 0;
    int total  = 0;

    function automatic logic [25:0] pack(input logic [3:0] g, input logic t,
                                         input logic [3:0] h, input logic [63:0] d);
        logic [15:0] b;
        b = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) b = d[i*16 +: 16];
        end
        return {g, t, h, |g, b};
    endfunction

    task automatic check_now(input int which, input string name);
        logic [25:0] act;
        logic [25:0] exp;
        if (which == 0) act = {g0, t0, h0, v0, bus0};
        else            act = {g1, t1, {1'b0, h1}, v1, bus1};
        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty, got grant=%b", name, act[25:22]);
            return;
        end
        exp = exp_q.pop_front();
        if (act !== exp)
            $display("FAIL %s (u%0d): got grant=%b to=%b hold=%0d valid=%b bus=%h, expected grant=%b to=%b hold=%0d valid=%b bus=%h",
                     name, which, act[25:22], act[21], act[20:17], act[16], act[15:0],
                     exp[25:22], exp[21], exp[20:17], exp[16], exp[15:0]);
        else
            passed++;
    endtask

    // ---------------------------------------------------------------- driver
    task automatic step(input int which, input logic [3:0] req, input logic [3:0] g,
                        input logic t, input logic [3:0] h, input string name);
        @(negedge Clk);
        if (which == 0) req0 = req;
        else            req1 = req;
        data_in = {16'($urandom_range(0, 65535)), 16'h1234,
                   16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
        exp_q.push_back(pack(g, t, h, data_in));
        @(posedge Clk);
        #1;
        check_now(which, name);
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic       timeout;
        logic [3:0] hold;
    } vec_t;

    vec_t tbl [12];

    initial begin
        // Single-source ownership of src2, then wrap-around fairness 3 -> 0 -> 2.
        // The pointer is 1 on entry.
        tbl[0]  = '{4'b0100, 4'b0100, 1'b0, 4'd1};
        tbl[1]  = '{4'b0100, 4'b0100, 1'b0, 4'd2};
        tbl[2]  = '{4'b0100, 4'b0100, 1'b0, 4'd3};
        tbl[3]  = '{4'b0000, 4'b0000, 1'b0, 4'd0};
        tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 4'd0};
        tbl[5]  = '{4'b1000, 4'b1000, 1'b0, 4'd1};
        tbl[6]  = '{4'b0101, 4'b0000, 1'b0, 4'd0};
        tbl[7]  = '{4'b0101, 4'b0001, 1'b0, 4'd1};
        tbl[8]  = '{4'b0100, 4'b0000, 1'b0, 4'd0};
        tbl[9]  = '{4'b0100, 4'b0100, 1'b0, 4'd1};
        tbl[10] = '{4'b0000, 4'b0000, 1'b0, 4'd0};
        tbl[11] = '{4'b0000, 4'b0000, 1'b0, 4'd0};

        Reset_n = 1'b0;
        req0    = 4'b0000;
        req1    = 4'b0000;
        data_in = {16'hD3D3, 16'h1234, 16'hB1B1, 16'hA0A0};
        #3;
        exp_q.push_back(pack(4'b0000, 1'b0, 4'd0, data_in));
        check_now(0, "reset_state");
        exp_q.push_back(pack(4'b0000, 1'b0, 4'd0, data_in));
        check_now(1, "reset_state");
        @(negedge Clk);
        Reset_n = 1'b1;

        // Saturation: all requesting, 8 cycles each, timeout gap, rotate.
        for (int s = 0; s < 4; s++) begin
            for (int h = 1; h <= 8; h++)
                step(0, 4'hF, 4'(1 << s), 1'b0, 4'(h), "sat_own");
            step(0, 4'hF, 4'b0000, 1'b1, 4'd0, "sat_gap_timeout");
        end
        step(0, 4'hF, 4'b0001, 1'b0, 4'd1, "sat_wrap_to_src0");
        step(0, 4'h0, 4'b0000, 1'b0, 4'd0, "sat_release");
        step(0, 4'h0, 4'b0000, 1'b0, 4'd0, "sat_idle");

        for (int i = 0; i < 12; i++)
            step(0, tbl[i].req, tbl[i].grant, tbl[i].timeout, tbl[i].hold, "table");

        // Voluntary drop on the limit cycle: no timeout, pointer advances by one.
        for (int h = 1; h <= 8; h++)
            step(0, 4'b1000, 4'b1000, 1'b0, 4'(h), "simul_own");
        step(0, 4'b0000, 4'b0000, 1'b0, 4'd0, "simul_no_timeout");
        step(0, 4'b0000, 4'b0000, 1'b0, 4'd0, "simul_idle");
        step(0, 4'b1111, 4'b0001, 1'b0, 4'd1, "simul_ptr_plus_one");
        step(0, 4'b0000, 4'b0000, 1'b0, 4'd0, "simul_release");
        step(0, 4'b0000, 4'b0000, 1'b0, 4'd0, "simul_idle2");

        // Asynchronous reset during ownership of src1.
        step(0, 4'b0010, 4'b0010, 1'b0, 4'd1, "pre_reset_own");
        step(0, 4'b0010, 4'b0010, 1'b0, 4'd2, "pre_reset_own");
        @(negedge Clk);
        #1 Reset_n = 1'b0;
        #1;
        exp_q.push_back(pack(4'b0000, 1'b0, 4'd0, data_in));
        check_now(0, "async_reset_immediate");
        @(negedge Clk);
        Reset_n = 1'b1;
        req0    = 4'b0000;
        step(0, 4'b1001, 4'b0001, 1'b0, 4'd1, "reset_ptr_zero");
        step(0, 4'b0000, 4'b0000, 1'b0, 4'd0, "reset_release");
        step(0, 4'b0000, 4'b0000, 1'b0, 4'd0, "reset_idle");
        step(0, 4'b1000, 4'b1000, 1'b0, 4'd1, "reset_then_src3");
        step(0, 4'b0000, 4'b0000, 1'b0, 4'd0, "src3_release");

        // TURN=0 instance: same-edge handoff and sole-requester re-grant.
        step(1, 4'b0011, 4'b0001, 1'b0, 4'd1, "turn0_own");
        step(1, 4'b0011, 4'b0001, 1'b0, 4'd2, "turn0_own");
        step(1, 4'b0010, 4'b0010, 1'b0, 4'd1, "turn0_handoff");
        step(1, 4'b0000, 4'b0000, 1'b0, 4'd0, "turn0_idle");
        for (int h = 1; h <= 4; h++)
            step(1, 4'b0001, 4'b0001, 1'b0, 4'(h), "turn0_sole_own");
        step(1, 4'b0001, 4'b0001, 1'b1, 4'd1, "turn0_regrant_timeout");
        step(1, 4'b0001, 4'b0001, 1'b0, 4'd2, "turn0_after_regrant");
        step(1, 4'b0000, 4'b0000, 1'b0, 4'd0, "turn0_release");

        // ---------------------------------------------------------------- report
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
